am_test_modulator: RTL
======================

# am_test_modulator

- Self-test AM signal source for the Tang Nano 9K, running on the 27 MHz board clock. It is the transmit counterpart of the AM demodulator path.
- Generates a triangle carrier that is amplitude-modulated by a triangle tone.
- Emits the signal two ways:
  - a 10-bit signed sample stream, for on-chip loopback into the demodulator;
  - a 1-bit first-order sigma-delta pin, for an external RC filter or antenna.
- Drives the 4 board LEDs as a status display.

## Interface
- CARRIER_FCW, 159072863: 32-bit carrier phase increment (~1 MHz at 27 MHz).
- TONE_FCW, 159073: 32-bit tone phase increment (~1 kHz).
- DEPTH, 128: modulation depth, 0..255 (128 = 50 %).

- clk_27m  in  1  board clock, 27 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable, sampled on the rising edge of clk_27m.
- sample  out  10  signed AM sample, two's complement.
- sample_valid  out  1  high while `sample` carries valid data.
- rf_out  out  1  sigma-delta bitstream.
- LED  out  4  status.

## Operation
- **Phase accumulators** (32 bit): carrier `pc` and tone `pt`.
  - Reset to 0.
  - Each advance by their FCW every cycle while en=1, wrapping modulo 2^32.
  - Hold their value while en=0.
- **Triangle function** tri(p), applied to the top 9 bits p[31:23]:
  - u = p[31] ? ~p[30:23] : p[30:23], range 0..255;
  - tri = u − 128, signed 9 bit, range −128..127.
- **Pipeline**, advancing only while en=1:
  - S1: c = tri(pc), m = tri(pt).
  - S2: env = 128 + ((m·DEPTH) >>> 8), arithmetic shift, range 0..254, 8-bit unsigned. c is delayed one stage alongside it.
  - S3: sample = (c·env) >>> 7, range −254..252.
- **Sigma-delta modulator**:
  - Input x = sample + 512, offset binary, 10 bit.
  - 11-bit accumulator a: a ← {1'b0, a[9:0]} + x.
  - rf_out = a[10] (registered).
- **sample_valid**: en delayed through a 3-stage shift register.
- **en = 0**:
  - sample, sample_valid, rf_out and a are cleared to 0 on the next edge.
  - Pipeline contents are discarded.
  - The valid shift register is cleared.
- **LED** (registered):
  - LED[0] = en.
  - LED[3:1] = pt[31:29], a visible tone-phase indicator at low TONE_FCW.
- **Reset** (rst_n low, any time, including mid-run): all registers go to 0. Outputs sample, sample_valid, rf_out and LED are therefore 0.

## Timing
- **Latency**: phase register → sample is 3 edges. en rise → first sample_valid=1 is the 3rd edge after en is sampled high.
- **sample** updates every cycle while valid. There is no back-pressure.
- **rf_out** updates every cycle while en=1. Its duty cycle over N cycles is (sample+512)/1024 ± 1/N.
- **en fall**: outputs are 0 one edge after en is sampled low.
- **en re-rise**: phases resume from their held values, and the valid latency is again 3.
- **Arithmetic**:
  - m·DEPTH: signed 9 × unsigned 8 → signed 17.
  - c·env: signed 9 × unsigned 8 → signed 17.
  - There is no saturation; the ranges above are guaranteed by construction.
- **FCW = 0**: the phase is frozen at 0. tri(0) = −128.

## Configuration
- Macro: AM_MOD_KEYING_EN.
- **Defined**:
  - A 24-bit key counter, reset 0, increments every cycle while en=1 and wraps.
  - While key_cnt[23]=1, the S2 modulation term is forced to 0 (env = 128, unmodulated carrier).
  - The result is tone-on/tone-off keying of ~0.31 s each half.
  - LED[0] shows key_cnt[23] instead of en.
- **Undefined**:
  - No counter.
  - The tone is continuous.
  - LED[0] = en.

## Test plan
- **Reset/start**: rst_n=0 with en=1 → sample, sample_valid, rf_out and LED are all 0. Release rst_n → sample_valid=1 on the 3rd edge, LED[0]=1.
- **Pure carrier**: CARRIER_FCW=2^24, TONE_FCW=0, DEPTH=0 → env=128 and sample = c, giving a triangle with period 256 cycles that spans −128..127 exactly.
- **Full-depth null**: TONE_FCW=0, DEPTH=255 → env=0, so sample=0 every cycle. rf_out follows the pattern 0,1,0,1… from the first valid cycle (a: 512, 1024→carry).
- **Wrap-around**: CARRIER_FCW=32'hFFFFFFFF → pc decrements by 1 per cycle, wrapping 0 → FFFFFFFF. There is no output discontinuity, and tri steps by at most 1 per 2^23 cycles.
- **Enable toggle**: drop en for 5 cycles mid-run → outputs are 0 one edge later, pc/pt hold. Raise en → sample_valid returns after 3 edges, and sample continues from the held phase.
- **Keying** (AM_MOD_KEYING_EN defined, TONE_FCW=2^24, DEPTH=255):
  - Cycles 0..2^23−1 are modulated; env varies over 0..254.
  - From cycle 2^23, env=128 constant.
  - LED[0] toggles at the 2^23 boundary.

Source files
------------

// File: rtl/am_test_modulator.sv
// Triangle-carrier AM self-test source: 10-bit signed sample stream plus 1-bit sigma-delta pin.
// Optional build macro AM_MOD_KEYING_EN adds ~0.31 s tone-on/tone-off keying of the modulation.
module am_test_modulator #(
    parameter logic [31:0] CARRIER_FCW = 32'd159072863,
    parameter logic [31:0] TONE_FCW    = 32'd159073,
    parameter logic [7:0]  DEPTH       = 8'd128
) (
    input  logic       clk_27m,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] sample,
    output logic       sample_valid,
    output logic       rf_out,
    output logic [3:0] LED
);

    // Signed values are carried as plain two's-complement vectors throughout.
    function automatic logic [8:0] tri_wave(input logic [8:0] top);
        logic [7:0] u;
        u = top[8] ? ~top[7:0] : top[7:0];
        return {1'b0, u} - 9'd128;
    endfunction

    logic [31:0] r_pc;
    logic [31:0] r_pt;
    logic [8:0]  r_c1;
    logic [8:0]  r_m1;
    logic [8:0]  r_c2;
    logic [7:0]  r_env2;
    logic [9:0]  r_sample;
    logic [2:0]  r_vld;
    logic [10:0] r_acc;
    logic [3:0]  r_led;

    logic [8:0]  w_c;
    logic [8:0]  w_m;
    logic [16:0] w_mod_prod;
    logic [8:0]  w_mod_term;
    logic [8:0]  w_mod_eff;
    logic [7:0]  w_env;
    logic [16:0] w_s3_prod;
    logic [9:0]  w_s3;
    logic [9:0]  w_x;
    logic [10:0] w_acc_next;
    logic        w_led0;

    // Sign-extending both operands to the product width makes the truncated product exact.
    always_comb begin
        w_c        = tri_wave(r_pc[31:23]);
        w_m        = tri_wave(r_pt[31:23]);
        w_mod_prod = {{8{r_m1[8]}}, r_m1} * {9'd0, DEPTH};
        w_mod_term = 9'(w_mod_prod >> 8);
        w_env      = 8'(9'd128 + w_mod_eff);
        w_s3_prod  = {{8{r_c2[8]}}, r_c2} * {9'd0, r_env2};
        w_s3       = 10'(w_s3_prod >> 7);
        w_x        = {~w_s3[9], w_s3[8:0]};
        w_acc_next = {1'b0, r_acc[9:0]} + {1'b0, w_x};
    end

`ifdef AM_MOD_KEYING_EN
    logic [23:0] r_key_cnt;

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            r_key_cnt <= '0;
        end else if (en) begin
            r_key_cnt <= r_key_cnt + 24'd1;
        end
    end

    assign w_mod_eff = r_key_cnt[23] ? '0 : w_mod_term;
    assign w_led0    = r_key_cnt[23];
`else
    assign w_mod_eff = w_mod_term;
    assign w_led0    = en;
`endif

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_pt     <= '0;
            r_c1     <= '0;
            r_m1     <= '0;
            r_c2     <= '0;
            r_env2   <= '0;
            r_sample <= '0;
            r_vld    <= '0;
            r_acc    <= '0;
        end else if (en) begin
            r_pc     <= r_pc + CARRIER_FCW;
            r_pt     <= r_pt + TONE_FCW;
            r_c1     <= w_c;
            r_m1     <= w_m;
            r_c2     <= r_c1;
            r_env2   <= w_env;
            r_sample <= w_s3;
            r_vld    <= {r_vld[1:0], 1'b1};
            r_acc    <= w_acc_next;
        end else begin
            // Phases hold; everything downstream is flushed so a restart refills cleanly.
            r_c1     <= '0;
            r_m1     <= '0;
            r_c2     <= '0;
            r_env2   <= '0;
            r_sample <= '0;
            r_vld    <= '0;
            r_acc    <= '0;
        end
    end

    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= {r_pt[31:29], w_led0};
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_vld[2];
    assign rf_out       = r_acc[10];
    assign LED          = r_led;

endmodule
